// File: rtl/down_timer_pkg.sv
// Shared types for the loadable down-counting timer.
// State encoding for the timer FSM.
package down_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/loadable_down_counter_parameter.sv
// Count register with load and decrement enable.
// Load wins over decrement; q saturates at zero.
module loadable_down_counter_parameter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_value,
    input  logic             dec,
    output logic [width-1:0] q
);

    localparam logic [width-1:0] ONE = width'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_value;
        end else if (dec && q != '0) begin
            q <= q - ONE;
        end
    end

endmodule

// File: rtl/down_timer_parameter.sv
// Programmable down timer: IDLE -> RUN -> DONE with a one-cycle done pulse.
// Define DOWN_TIMER_AUTO_RELOAD_EN for periodic (auto-reload) operation.
module down_timer_parameter
    import down_timer_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_value,
    input  logic             start,
    input  logic             abort,
    input  logic             tick,
    output logic [width-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam logic [width-1:0] ONE = width'(1);

    timer_state_t     state;
    timer_state_t     next;
    logic             cnt_load;
    logic             cnt_dec;
    logic [width-1:0] cnt_value;
    logic [width-1:0] eff;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [width-1:0] reload;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload <= '0;
        end else if (state == IDLE && load) begin
            reload <= load_value;
        end
    end
`endif

    loadable_down_counter_parameter #(.width(width)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .q          (q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next      = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_value = load_value;
        eff       = load ? load_value : q;
        case (state)
            IDLE: begin
                cnt_load = load;
                if (start && !abort) begin
                    next = (eff != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    next = IDLE;
                end else if (tick) begin
                    cnt_dec = 1'b1;
                    if (q <= ONE) begin
                        next = DONE;
                    end
                end
            end
            DONE: begin
                next = IDLE;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                // Periodic mode restarts from the captured load value.
                if (!abort && reload != '0) begin
                    next      = RUN;
                    cnt_load  = 1'b1;
                    cnt_value = reload;
                end
`endif
            end
            default: next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign zero = (q == '0);

endmodule

// File: tb/tb_down_timer_parameter.sv
// Self-checking bench for down_timer_parameter.
// Vector table plus hand sequences, scored through an expectation queue.
module tb_down_timer_parameter;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       abort;
    logic       tick;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       zero;

    int tests;
    int failed;

    typedef struct {
        string      name;
        logic       ld;
        logic [7:0] lv;
        logic       st;
        logic       ab;
        logic       tk;
        logic [7:0] eq;
        logic       eb;
        logic       ed;
        logic       ez;
    } vec_t;

    vec_t       tbl[$];
    logic [10:0] sb[$];
    string      sb_name[$];

    down_timer_parameter #(.width(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .abort      (abort),
        .tick       (tick),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic ld, logic [7:0] lv,
                                logic st, logic ab, logic tk,
                                logic [7:0] eq, logic eb, logic ed);
        vec_t v;
        v.name = n;
        v.ld = ld; v.lv = lv; v.st = st; v.ab = ab; v.tk = tk;
        v.eq = eq; v.eb = eb; v.ed = ed; v.ez = (eq == 8'd0);
        return v;
    endfunction

    task automatic chk(string n, logic [10:0] exp);
        logic [10:0] got;
        got = {q, busy, done, zero};
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got q=%0d busy=%0b done=%0b zero=%0b, expected q=%0d busy=%0b done=%0b zero=%0b",
                     n, got[10:3], got[2], got[1], got[0],
                     exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(logic ld, logic [7:0] lv, logic st, logic ab, logic tk);
        load = ld; load_value = lv; start = st; abort = ab; tick = tk;
    endtask

    task automatic step(vec_t v);
        drive(v.ld, v.lv, v.st, v.ab, v.tk);
        sb.push_back({v.eq, v.eb, v.ed, v.ez});
        sb_name.push_back(v.name);
        @(posedge clk);
        #1;
        chk(sb_name.pop_front(), sb.pop_front());
    endtask

    initial begin
        int busy_cnt;
        bit seen;
        tests  = 0;
        failed = 0;
        reset  = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset", {8'd0, 1'b0, 1'b0, 1'b1});
        reset = 1'b1;

        tbl.push_back(mk("idle0", 0, 8'd0, 0, 0, 0, 8'd0, 0, 0));
        tbl.push_back(mk("idle1", 0, 8'd0, 0, 0, 0, 8'd0, 0, 0));
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        tbl.push_back(mk("ar_start", 1, 8'd3, 1, 0, 1, 8'd3, 1, 0));
        tbl.push_back(mk("ar_2",     0, 8'd0, 0, 0, 1, 8'd2, 1, 0));
        tbl.push_back(mk("ar_1",     0, 8'd0, 0, 0, 1, 8'd1, 1, 0));
        tbl.push_back(mk("ar_done1", 0, 8'd0, 0, 0, 1, 8'd0, 0, 1));
        tbl.push_back(mk("ar_rel1",  0, 8'd0, 0, 0, 1, 8'd3, 1, 0));
        tbl.push_back(mk("ar_2b",    0, 8'd0, 0, 0, 1, 8'd2, 1, 0));
        tbl.push_back(mk("ar_1b",    0, 8'd0, 0, 0, 1, 8'd1, 1, 0));
        tbl.push_back(mk("ar_done2", 0, 8'd0, 0, 0, 1, 8'd0, 0, 1));
        tbl.push_back(mk("ar_rel2",  0, 8'd0, 0, 0, 1, 8'd3, 1, 0));
        tbl.push_back(mk("ar_abort", 0, 8'd0, 0, 1, 1, 8'd3, 0, 0));
        tbl.push_back(mk("ar_idle",  0, 8'd0, 0, 0, 1, 8'd3, 0, 0));
        tbl.push_back(mk("ar_z",     1, 8'd0, 1, 0, 0, 8'd0, 0, 1));
        tbl.push_back(mk("ar_z_idle",0, 8'd0, 0, 0, 0, 8'd0, 0, 0));
        tbl.push_back(mk("ar_s2",    1, 8'd2, 1, 0, 1, 8'd2, 1, 0));
        tbl.push_back(mk("ar_s2_1",  0, 8'd0, 0, 0, 1, 8'd1, 1, 0));
        tbl.push_back(mk("ar_s2_d",  0, 8'd0, 0, 0, 1, 8'd0, 0, 1));
        tbl.push_back(mk("ar_dab",   0, 8'd0, 0, 1, 1, 8'd0, 0, 0));
`else
        tbl.push_back(mk("cd_5",     1, 8'd5, 1, 0, 1, 8'd5, 1, 0));
        tbl.push_back(mk("cd_4",     0, 8'd0, 0, 0, 1, 8'd4, 1, 0));
        tbl.push_back(mk("cd_3",     0, 8'd0, 0, 0, 1, 8'd3, 1, 0));
        tbl.push_back(mk("cd_2",     0, 8'd0, 0, 0, 1, 8'd2, 1, 0));
        tbl.push_back(mk("cd_1",     0, 8'd0, 0, 0, 1, 8'd1, 1, 0));
        tbl.push_back(mk("cd_done",  0, 8'd0, 0, 0, 1, 8'd0, 0, 1));
        tbl.push_back(mk("cd_idle",  0, 8'd0, 0, 0, 1, 8'd0, 0, 0));
        tbl.push_back(mk("tg_start", 1, 8'd3, 1, 0, 0, 8'd3, 1, 0));
        tbl.push_back(mk("tg_t1",    0, 8'd0, 0, 0, 1, 8'd2, 1, 0));
        tbl.push_back(mk("tg_h1",    0, 8'd0, 0, 0, 0, 8'd2, 1, 0));
        tbl.push_back(mk("tg_t2",    0, 8'd0, 0, 0, 1, 8'd1, 1, 0));
        tbl.push_back(mk("tg_h2",    0, 8'd0, 0, 0, 0, 8'd1, 1, 0));
        tbl.push_back(mk("tg_done",  0, 8'd0, 0, 0, 1, 8'd0, 0, 1));
        tbl.push_back(mk("tg_idle",  0, 8'd0, 0, 0, 0, 8'd0, 0, 0));
        tbl.push_back(mk("ab_start", 1, 8'd10, 1, 0, 1, 8'd10, 1, 0));
        tbl.push_back(mk("ab_9",     0, 8'd0, 0, 0, 1, 8'd9, 1, 0));
        tbl.push_back(mk("ab_8",     1, 8'd50, 1, 0, 1, 8'd8, 1, 0));
        tbl.push_back(mk("ab_7",     0, 8'd0, 0, 0, 1, 8'd7, 1, 0));
        tbl.push_back(mk("ab_6",     0, 8'd0, 0, 0, 1, 8'd6, 1, 0));
        tbl.push_back(mk("ab_abort", 0, 8'd0, 0, 1, 1, 8'd6, 0, 0));
        tbl.push_back(mk("ab_hold",  0, 8'd0, 0, 0, 1, 8'd6, 0, 0));
        tbl.push_back(mk("ab_st",    0, 8'd0, 1, 1, 1, 8'd6, 0, 0));
        tbl.push_back(mk("ab_ld_st", 1, 8'd9, 1, 1, 0, 8'd9, 0, 0));
        tbl.push_back(mk("q_start",  0, 8'd0, 1, 0, 0, 8'd9, 1, 0));
        tbl.push_back(mk("q_abort",  0, 8'd0, 0, 1, 0, 8'd9, 0, 0));
        tbl.push_back(mk("ld_only",  1, 8'd4, 0, 0, 1, 8'd4, 0, 0));
        tbl.push_back(mk("z_start",  1, 8'd0, 1, 0, 1, 8'd0, 0, 1));
        tbl.push_back(mk("z_idle",   0, 8'd0, 0, 0, 1, 8'd0, 0, 0));
        tbl.push_back(mk("z_q_st",   0, 8'd0, 1, 0, 0, 8'd0, 0, 1));
        tbl.push_back(mk("z_q_idle", 0, 8'd0, 0, 0, 0, 8'd0, 0, 0));
        tbl.push_back(mk("ff_start", 1, 8'd255, 1, 0, 1, 8'd255, 1, 0));
        tbl.push_back(mk("ff_254",   0, 8'd0, 0, 0, 1, 8'd254, 1, 0));
        tbl.push_back(mk("ff_abort", 0, 8'd0, 0, 1, 0, 8'd254, 0, 0));
`endif
        tbl.push_back(mk("rm_start", 1, 8'd9, 1, 0, 1, 8'd9, 1, 0));
        tbl.push_back(mk("rm_8",     0, 8'd0, 0, 0, 1, 8'd8, 1, 0));
        tbl.push_back(mk("rm_7",     0, 8'd0, 0, 0, 1, 8'd7, 1, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Asynchronous reset in the middle of a run.
        #2;
        reset = 1'b0;
        #1;
        chk("rm_async", {8'd0, 1'b0, 1'b0, 1'b1});
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rm_held", {8'd0, 1'b0, 1'b0, 1'b1});
        end
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rm_after", {8'd0, 1'b0, 1'b0, 1'b1});

        // Latency: busy for exactly V cycles, then one done cycle.
        drive(1'b1, 8'd6, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        busy_cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cnt++;
                @(posedge clk);
                #1;
            end
        end
        tests++;
        if (!seen) begin
            failed++;
            $display("FAIL lat_timeout: got no done in 20 cycles, expected done");
        end
        tests++;
        if (busy_cnt != 6) begin
            failed++;
            $display("FAIL lat_busy: got %0d busy cycles, expected 6", busy_cnt);
        end
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_after", {8'd0, 1'b0, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/down_timer_parameter.md
Name: down_timer_parameter

Overview:
- Loadable, programmable down-counting timer. It is the count-down counterpart of the team's free-running up counters.
- Software/control logic loads a terminal value and pulses start. The block decrements on each enabled tick and signals completion with a one-cycle done pulse.
- Used as a delay/timeout generator beside the counter library in control datapaths.

Parameters:
- width, 8, bit width of count value and load_value.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately).
- load  input  1  load q from load_value (honoured only in IDLE).
- load_value  input  width  value to load.
- start  input  1  begin countdown (honoured only in IDLE).
- abort  input  1  stop countdown, return to IDLE, q holds.
- tick  input  1  decrement enable while RUN.
- q  output  width  current count.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- zero  output  1  combinational (q == 0).

Behaviour:
- Reset (reset=0, async): state=IDLE, q=0, busy=0, done=0. The reload register is cleared. Reset mid-RUN aborts with no done pulse.
- States: IDLE, RUN, DONE. The state is registered. busy=1 iff state==RUN. done=1 iff state==DONE.
- IDLE:
  - load=1 -> q<=load_value.
  - start=1 with effective value != 0 -> RUN. The effective value is load_value if load is also high, else q.
  - start=1 with effective value == 0 -> DONE directly (zero-length timer still pulses done).
  - load and start in the same cycle: the load takes effect and counting begins from load_value.
- RUN:
  - tick=1 and q>1 -> q<=q-1.
  - tick=1 and q==1 -> q<=0, next state DONE.
  - tick=0 -> hold.
  - load and start are ignored.
- Abort:
  - abort=1 in RUN -> IDLE, q holds its current value, no done.
  - abort has priority over tick in the same cycle.
  - In IDLE, abort has priority over start; load still applies.
- DONE: lasts exactly one cycle, then IDLE with q=0 (see Optional Feature for the alternative). abort in DONE -> IDLE; the done pulse for that cycle is still visible.
- Latency: start sampled at edge E0 with value V and tick held high -> busy high for V cycles, then done high for the single cycle following edge E0+V.
- No wrap-around: q never decrements below 0. Underflow is impossible by construction.
- All arithmetic is unsigned, width bits.

Optional Feature:
- Macro: DOWN_TIMER_AUTO_RELOAD_EN.
- When defined:
  - A width-bit reload register captures load_value on every honoured load.
  - On leaving DONE, q<=reload register and the state returns to RUN (periodic mode), with done pulsing once per period.
  - If the reload value is 0, the state goes to IDLE instead.
  - abort is the only way to stop the timer.
- When undefined: no reload register is built. DONE always returns to IDLE with q=0.

Decomposition:
- Package down_timer_pkg: typedef enum logic [1:0] timer_state_t {IDLE, RUN, DONE}, plus a localparam for state encoding width.
- One natural sub-module: loadable_down_counter_parameter #(width). It is the q register with async active-low reset, load, and decrement-enable, and is instantiated once.
- The FSM and the done/busy decode stay in the top module.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> q=0, busy=0, done=0, zero=1. No activity with all inputs low.
- Basic countdown: load_value=5, load+start same cycle, tick=1 -> busy for 5 cycles, q sequence 5,4,3,2,1,0, done high exactly 1 cycle, then IDLE.
- Tick gating: V=3, tick toggling 1,0,1,0,1 -> q holds on tick=0 cycles, done after the 3rd tick.
- Abort: V=10, abort after 4 ticks -> IDLE, q=6, no done. abort+start same cycle in IDLE -> stays IDLE.
- Zero load and reset mid-run: start with V=0 -> done pulse the next cycle, busy never set. Reset asserted mid-RUN at q=7 -> q=0 immediately, no done.
- Auto reload (DOWN_TIMER_AUTO_RELOAD_EN defined): V=3, tick=1 -> done every 4th cycle, repeating, until abort returns the block to IDLE.
